// File: rtl/md_issue_ctrl_pkg.sv
// md_issue_ctrl_pkg: shared MD op codes and issue-controller state encodings
package md_issue_ctrl_pkg;
   localparam logic [2:0] OP_MULT    = 3'd0;
   localparam logic [2:0] OP_MULTU   = 3'd1;
   localparam logic [2:0] OP_DIV     = 3'd2;
   localparam logic [2:0] OP_DIVU    = 3'd3;
   localparam logic [2:0] OP_MTHI    = 3'd4;
   localparam logic [2:0] OP_MTLO    = 3'd5;
   localparam logic [2:0] OP_MF      = 3'd6;
   localparam logic [2:0] MD_IDLE_OP = 3'd7;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} md_state_e;
endpackage

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue, stall and latency tracking for the HI/LO multiply/divide unit
module md_issue_ctrl
   import md_issue_ctrl_pkg::*;
#(
   parameter int          MAX_WAIT = 16,
   parameter logic [2:0]  IDLE_OP  = MD_IDLE_OP
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        e_md_req,
   input  logic [2:0]  e_md_op,
   input  logic        e_mf_hi,
   input  logic [31:0] e_a,
   input  logic [31:0] e_b,
   input  logic        e_flush,
   output logic        e_md_ready,
   output logic        stall,
   output logic [31:0] e_md_rdata,
   output logic        md_start,
   output logic [2:0]  md_op,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_busy,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic [7:0]  last_latency,
   output logic        md_timeout
);
   localparam logic [7:0] L_MAX_WAIT = 8'(MAX_WAIT);
   md_state_e   r_state, w_state_nxt;
   logic [2:0]  r_op;
   logic [31:0] r_a, r_b;
   logic [7:0]  r_wait_cnt, w_cnt_inc;
   logic        w_in_wait, w_accept, w_is_md;
   assign w_in_wait    = (r_state == S_WAIT);
   assign e_md_ready   = ((r_state == S_IDLE) | (w_in_wait & ~md_busy)) & ~e_flush;
   assign stall        = e_md_req & ~e_md_ready;
   assign w_accept     = e_md_req & e_md_ready;
   assign w_is_md      = (e_md_op <= OP_MTLO);
   assign e_md_rdata   = e_mf_hi ? md_hi : md_lo;
   // ops 4/5 are acted on by the unit whenever it is idle, so md_op must only carry a real op in ISSUE
   assign md_start     = (r_state == S_ISSUE) & (r_op <= OP_DIVU);
   assign md_op        = (r_state == S_ISSUE) ? r_op : IDLE_OP;
   assign md_a         = r_a;
   assign md_b         = r_b;
   assign w_cnt_inc    = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
   // next state: ISSUE lasts one cycle, WAIT holds while busy, otherwise follow acceptance
   always_comb begin
      w_state_nxt = S_IDLE;
      w_state_nxt = (r_state == S_ISSUE)  ? (md_start ? S_WAIT : S_IDLE) :
                    (w_in_wait & md_busy) ? S_WAIT :
                    (w_accept & w_is_md)  ? S_ISSUE : S_IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end
   // capture the accepted op and operands; they stay on md_a/md_b afterwards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op <= 3'd0;
         r_a  <= 32'd0;
         r_b  <= 32'd0;
      end else if (w_accept & w_is_md) begin
         r_op <= e_md_op;
         r_a  <= e_a;
         r_b  <= e_b;
      end
   end
   // count busy cycles in WAIT, publish on completion, and latch a stuck unit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wait_cnt   <= 8'd0;
         last_latency <= 8'd0;
         md_timeout   <= 1'b0;
      end else if (w_in_wait & md_busy) begin
         r_wait_cnt   <= w_cnt_inc;
         md_timeout   <= md_timeout | (w_cnt_inc >= L_MAX_WAIT);
      end else if (w_in_wait) begin
         r_wait_cnt   <= 8'd0;
         last_latency <= r_wait_cnt;
      end
   end
endmodule
